// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART framing protocol (SOF, CRC-8 and receive states).
package uart_frame_pkg;

    localparam logic [7:0] SOF_BYTE  = 8'hA5;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        TYPE,
        PAYLOAD,
        CRC,
        HOLD
    } rx_state_t;

    // CRC-8, MSB-first, no reflection, no final XOR; one byte per call.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_frame_rx.sv
// Receive-side frame parser: hunts for SOF, checks CRC-8 per byte and presents
// each clean frame on a valid/ready interface until the consumer accepts it.
//
// state   | meaning
// HUNT    | waiting for SOF, other bytes ignored
// LEN     | next byte is payload length
// TYPE    | next byte is frame type
// PAYLOAD | collecting payload bytes
// CRC     | next byte is compared with the running CRC
// HOLD    | good frame presented, waiting for frame_ready
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int MAX_PAYLOAD    = 255,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_byte,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic [7:0]                    frame_len,
    output logic [7:0]                    frame_type,
    output logic [MAX_PAYLOAD-1:0][7:0]   frame_payload,
    output logic                          crc_err,
    output logic                          len_err,
    output logic                          timeout_err,
    output logic                          drop
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    rx_state_t   state;
    rx_state_t   state_next;
    logic [7:0]  crc;
    logic [7:0]  idx;
    logic [TW-1:0] timer;
    logic        parsing;
    logic        crc_err_next;
    logic        len_err_next;
    logic        timeout_err_next;
    logic        drop_next;

    assign parsing     = (state == LEN) || (state == TYPE) || (state == PAYLOAD) || (state == CRC);
    assign frame_valid = (state == HOLD);

    always_comb begin
        state_next       = state;
        crc_err_next     = 1'b0;
        len_err_next     = 1'b0;
        timeout_err_next = 1'b0;
        drop_next        = 1'b0;
        case (state)
            HUNT: begin
                if (rx_valid && (rx_byte == SOF_BYTE)) state_next = LEN;
            end
            LEN: begin
                if (rx_valid) begin
                    if (int'(rx_byte) > MAX_PAYLOAD) begin
                        len_err_next = 1'b1;
                        state_next   = HUNT;
                    end else begin
                        state_next = TYPE;
                    end
                end
            end
            TYPE: begin
                if (rx_valid) state_next = (frame_len == 8'd0) ? CRC : PAYLOAD;
            end
            PAYLOAD: begin
                if (rx_valid && (idx == frame_len - 8'd1)) state_next = CRC;
            end
            CRC: begin
                if (rx_valid) begin
                    if (rx_byte == crc) begin
                        state_next = HOLD;
                    end else begin
                        crc_err_next = 1'b1;
                        state_next   = HUNT;
                    end
                end
            end
            HOLD: begin
                drop_next = rx_valid;
                if (frame_ready) state_next = HUNT;
            end
            default: state_next = HUNT;
        endcase
        // A byte arriving on the expiry cycle keeps the frame alive.
        if ((TIMEOUT_CYCLES > 0) && parsing && !rx_valid && (timer == TW'(1))) begin
            timeout_err_next = 1'b1;
            state_next       = HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            frame_len   <= 8'd0;
            frame_type  <= 8'd0;
            crc         <= 8'd0;
            idx         <= 8'd0;
            crc_err     <= 1'b0;
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
            drop        <= 1'b0;
        end else begin
            state       <= state_next;
            crc_err     <= crc_err_next;
            len_err     <= len_err_next;
            timeout_err <= timeout_err_next;
            drop        <= drop_next;
            if (rx_valid) begin
                case (state)
                    LEN: begin
                        frame_len <= rx_byte;
                        crc       <= crc8_update(8'h00, rx_byte);
                    end
                    TYPE: begin
                        frame_type <= rx_byte;
                        crc        <= crc8_update(crc, rx_byte);
                        idx        <= 8'd0;
                    end
                    PAYLOAD: begin
                        crc <= crc8_update(crc, rx_byte);
                        idx <= idx + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Inter-byte timer: reloads on every byte, counts down while parsing.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (rx_valid) begin
            timer <= TW'(TIMEOUT_CYCLES);
        end else if (parsing && (timer != '0)) begin
            timer <= timer - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_valid && (state == PAYLOAD)) begin
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
                if (idx == 8'(i)) frame_payload[i] <= rx_byte;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: stimulus pushes expected events, a monitor pops and compares.
module tb_uart_frame_rx;

    localparam int MAXP = 16;
    localparam int TOC  = 8;
    localparam int K_FRAME = 0, K_CRC = 1, K_LEN = 2, K_TO = 3, K_DROP = 4;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [2:0]           kind;
        logic [7:0]           len;
        logic [7:0]           typ;
        logic [MAXP-1:0][7:0] pl;
    } exp_t;

    logic clk = 1'b0;
    logic rst, rx_valid, frame_valid, frame_ready, crc_err, len_err, timeout_err, drop;
    logic [7:0] rx_byte, frame_len, frame_type;
    logic [MAXP-1:0][7:0] frame_payload;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t cur;
    logic fv_prev = 1'b0;

    always #5 clk = ~clk;

    uart_frame_rx #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TOC)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_len(frame_len), .frame_type(frame_type), .frame_payload(frame_payload),
        .crc_err(crc_err), .len_err(len_err), .timeout_err(timeout_err), .drop(drop)
    );

    // CRC as the remainder of (message * x^8) divided by x^8+x^2+x+1.
    function automatic logic [7:0] ref_crc(input bq_t msg);
        logic [8:0] r;
        r = '0;
        for (int i = 0; i < msg.size() + 1; i++) begin
            logic [7:0] b;
            b = (i < msg.size()) ? msg[i] : 8'h00;
            for (int k = 7; k >= 0; k--) begin
                r = {r[7:0], b[k]};
                if (r[8]) r = r ^ 9'h107;
            end
        end
        return r[7:0];
    endfunction

    function automatic void push(input int kind, input int len, input int typ, input logic [MAXP-1:0][7:0] pl);
        exp_t e;
        e.kind = 3'(kind);
        e.len  = 8'(len);
        e.typ  = 8'(typ);
        e.pl   = pl;
        exp_q.push_back(e);
    endfunction

    task automatic check_event(input int kind);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind %0d, scoreboard empty", kind);
            return;
        end
        e = exp_q.pop_front();
        if (int'(e.kind) != kind) begin
            n_err++;
            $display("FAIL event_kind: got kind %0d, required kind %0d", kind, e.kind);
        end else if (kind == K_FRAME) begin
            cur = e;
            if (frame_len !== e.len || frame_type !== e.typ) begin
                n_err++;
                $display("FAIL frame_hdr: got len %h type %h, required len %h type %h",
                         frame_len, frame_type, e.len, e.typ);
            end
            for (int i = 0; i < int'(e.len); i++) begin
                if (frame_payload[i] !== e.pl[i]) begin
                    n_err++;
                    $display("FAIL payload[%0d]: got %h, required %h", i, frame_payload[i], e.pl[i]);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if ((int'(crc_err) + int'(len_err) + int'(timeout_err) + int'(drop)) > 1) begin
                n_err++;
                $display("FAIL pulse_excl: crc %b len %b to %b drop %b, required at most one",
                         crc_err, len_err, timeout_err, drop);
            end
            if (frame_valid && !fv_prev) begin
                check_event(K_FRAME);
            end else if (frame_valid) begin
                n_cmp++;
                if (frame_len !== cur.len || frame_type !== cur.typ) begin
                    n_err++;
                    $display("FAIL hold_stable: got len %h type %h, required len %h type %h",
                             frame_len, frame_type, cur.len, cur.typ);
                end
            end
            if (crc_err)     check_event(K_CRC);
            if (len_err)     check_event(K_LEN);
            if (timeout_err) check_event(K_TO);
            if (drop)        check_event(K_DROP);
        end
        fv_prev = rst ? 1'b0 : frame_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_lit(input logic [63:0] v, input int n, input int gap);
        for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8], gap);
    endtask

    task automatic handshake(input int ndrops, input bit samecyc);
        int w;
        w = 0;
        while (!frame_valid && w < 10) begin
            tick();
            w++;
        end
        n_cmp++;
        if (!frame_valid) begin
            n_err++;
            $display("FAIL hold_wait: frame_valid %b, required 1 within 10 cycles", frame_valid);
        end
        for (int i = 0; i < ndrops; i++) begin
            push(K_DROP, 0, 0, '0);
            send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 2));
        end
        if (samecyc) begin
            push(K_DROP, 0, 0, '0);
            rx_byte  = ($urandom_range(0, 1) == 1) ? 8'hA5 : 8'($urandom_range(0, 255));
            rx_valid = 1'b1;
        end
        frame_ready = 1'b1;
        tick();
        rx_valid    = 1'b0;
        frame_ready = 1'b0;
        n_cmp++;
        if (frame_valid !== 1'b0) begin
            n_err++;
            $display("FAIL release: frame_valid %b after accept, required 0", frame_valid);
        end
    endtask

    task automatic send_frame(input int len, input int typ, input logic [MAXP-1:0][7:0] pl, input bit bad,
                              input int gmin, input int gmax, input int ndrops, input bit samecyc);
        bq_t m;
        logic [7:0] c;
        if (len > MAXP) begin
            push(K_LEN, 0, 0, '0);
            send_byte(8'hA5, $urandom_range(gmin, gmax));
            send_byte(8'(len), $urandom_range(gmin, gmax));
            return;
        end
        m.push_back(8'(len));
        m.push_back(8'(typ));
        for (int i = 0; i < len; i++) m.push_back(pl[i]);
        c = ref_crc(m);
        if (bad) c = c ^ 8'($urandom_range(1, 255));
        push(bad ? K_CRC : K_FRAME, len, typ, pl);
        send_byte(8'hA5, $urandom_range(gmin, gmax));
        foreach (m[i]) send_byte(m[i], $urandom_range(gmin, gmax));
        send_byte(c, $urandom_range(gmin, gmax));
        if (!bad) handshake(ndrops, samecyc);
    endtask

    task automatic send_timeout(input int nbytes);
        send_byte(8'hA5, 0);
        for (int i = 0; i < nbytes; i++) send_byte(8'($urandom_range(0, MAXP)), 0);
        repeat (TOC - 1) tick();
        push(K_TO, 0, 0, '0);
        repeat (3) tick();
    endtask

    function automatic logic [MAXP-1:0][7:0] rand_pl();
        logic [MAXP-1:0][7:0] p;
        for (int i = 0; i < MAXP; i++)
            p[i] = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
        return p;
    endfunction

    initial begin
        logic [MAXP-1:0][7:0] pl;
        rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; frame_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        n_cmp++;
        if (frame_valid !== 1'b0 || frame_len !== 8'h00 || frame_type !== 8'h00 ||
            crc_err !== 1'b0 || len_err !== 1'b0 || timeout_err !== 1'b0 || drop !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: fv %b len %h type %h errs %b%b%b%b, required all 0",
                     frame_valid, frame_len, frame_type, crc_err, len_err, timeout_err, drop);
        end

        // good frame, one byte per 3 cycles
        pl = '0; pl[0] = 8'h03; pl[1] = 8'h04;
        push(K_FRAME, 2, 1, pl);
        send_lit(64'hA5_02_01_03_04_64, 6, 2);
        handshake(0, 1'b0);

        // zero-length good then bad CRC
        push(K_FRAME, 0, 5, '0);
        send_lit(64'hA5_00_05_1B, 4, 0);
        handshake(0, 1'b0);
        push(K_CRC, 0, 0, '0);
        send_lit(64'hA5_00_05_1C, 4, 0);

        // garbage, then embedded SOF in payload; then length errors at and past the limit
        send_lit(64'h11_22, 2, 0);
        pl = '0; pl[0] = 8'hA5; pl[1] = 8'h04;
        send_frame(2, 1, pl, 1'b0, 0, 1, 0, 1'b0);
        send_frame(255, 0, '0, 1'b0, 0, 0, 0, 1'b0);
        send_frame(MAXP + 1, 0, '0, 1'b0, 0, 0, 0, 1'b0);
        send_frame(MAXP, 8'h3C, rand_pl(), 1'b0, 0, 0, 0, 1'b0);

        // backpressure: three dropped bytes, then a normal frame
        send_frame(3, 7, rand_pl(), 1'b0, 0, 0, 3, 1'b0);
        send_frame(4, 9, rand_pl(), 1'b0, 0, 0, 0, 1'b1);

        // timeout after A5 02, then largest gap that must not time out
        send_timeout(1);
        send_frame(5, 2, rand_pl(), 1'b0, TOC - 1, TOC - 1, 0, 1'b0);

        // reset mid-frame
        send_lit(64'hA5_02_01_03, 4, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (frame_valid !== 1'b0 || frame_len !== 8'h00 || frame_type !== 8'h00) begin
            n_err++;
            $display("FAIL midframe_reset: fv %b len %h type %h, required 0 00 00",
                     frame_valid, frame_len, frame_type);
        end
        send_frame(2, 1, rand_pl(), 1'b0, 0, 2, 0, 1'b0);

        for (int it = 0; it < 60; it++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel <= 5)
                send_frame($urandom_range(0, MAXP), $urandom_range(0, 255), rand_pl(), 1'b0, 0,
                           $urandom_range(0, TOC - 1), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            else if (sel == 6)
                send_frame($urandom_range(0, MAXP), $urandom_range(0, 255), rand_pl(), 1'b1, 0, 2, 0, 1'b0);
            else if (sel == 7)
                send_frame($urandom_range(MAXP + 1, 255), 0, '0, 1'b0, 0, 2, 0, 1'b0);
            else if (sel == 8)
                send_timeout($urandom_range(0, 2));
            else
                for (int g = 0; g < $urandom_range(1, 3); g++)
                    send_byte(8'($urandom_range(0, 8'hA4)), $urandom_range(0, 2));
        end

        repeat (5) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: %0d expected events never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Receive-side frame parser for the UART framing protocol.
- Consumes the byte stream from the UART RX deserializer and hunts for SOF.
- Parses LEN, TYPE, PAYLOAD and CRC, checking CRC-8 in a streaming fashion, one update per byte.
- Presents each complete, CRC-clean frame on a valid/ready interface to the command/decode layer.

Parameters:
- MAX_PAYLOAD, 255: payload buffer depth in bytes (1..255); a larger LEN is a length error.
- TIMEOUT_CYCLES, 0: maximum clk cycles between bytes inside a frame; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rx_valid  in  1  one-cycle strobe, rx_byte valid; no backpressure available
- rx_byte  in  8  received byte
- frame_valid  out  1  complete good frame held on outputs
- frame_ready  in  1  consumer accepts frame when frame_valid && frame_ready
- frame_len  out  8  payload length
- frame_type  out  8  frame type byte
- frame_payload  out  8 x MAX_PAYLOAD  payload bytes; index 0 = first received
- crc_err  out  1  one-cycle pulse: CRC mismatch, frame discarded
- len_err  out  1  one-cycle pulse: LEN > MAX_PAYLOAD, frame discarded
- timeout_err  out  1  one-cycle pulse: inter-byte timeout, partial frame discarded
- drop  out  1  one-cycle pulse: byte arrived while in HOLD and was discarded

Behaviour:
- Frame on wire: 0xA5, LEN, TYPE, PAYLOAD[0..LEN-1], CRC.
- CRC-8 definition:
  - poly 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Covers LEN, TYPE and the payload; SOF and the CRC byte itself are excluded.
- Reset values:
  - state = HUNT.
  - frame_valid, crc_err, len_err, timeout_err and drop all 0.
  - frame_len = 0, frame_type = 0, crc = 0, idx = 0.
  - Payload array is not reset.
- Reset mid-frame: the partial frame is discarded with no error pulse.
- States and transitions, all on rx_valid unless noted:
  - HUNT: byte == 0xA5 -> LEN; any other byte is ignored silently.
  - LEN: latch frame_len, crc <= crc8(0, byte).
    - byte > MAX_PAYLOAD -> pulse len_err, go to HUNT.
    - Otherwise -> TYPE.
  - TYPE: latch frame_type and update crc.
    - frame_len == 0 -> CRC; otherwise -> PAYLOAD with idx = 0.
  - PAYLOAD: frame_payload[idx] <= byte, update crc, idx++.
    - idx == frame_len-1 -> CRC.
  - CRC: compare byte with the running crc.
    - Equal -> HOLD, and frame_valid = 1 next cycle (1-cycle latency after the CRC byte).
    - Not equal -> pulse crc_err, go to HUNT.
    - A 0xA5 received in the CRC state is treated as a CRC byte, never as a resync.
  - HOLD: outputs stay stable while frame_valid = 1.
    - frame_valid && frame_ready -> HUNT; frame_valid drops the next cycle.
    - rx_valid in HOLD -> pulse drop; the byte is lost, even if it is 0xA5.
    - Accept and rx_valid in the same cycle: the byte is dropped (drop pulses) and the state goes to HUNT.
- 0xA5 bytes inside LEN, TYPE or PAYLOAD are data; there is no byte stuffing.
- Timeout (only when TIMEOUT_CYCLES > 0):
  - Counter runs in LEN, TYPE, PAYLOAD and CRC.
  - Cleared on every rx_valid.
  - Reaching TIMEOUT_CYCLES -> pulse timeout_err, go to HUNT.
  - rx_valid in the same cycle as expiry wins: the byte is processed and no timeout fires.
- Error pulses are mutually exclusive and last exactly one cycle.
- frame_len, frame_type and frame_payload change only while parsing (not in HOLD). Consumers must sample them only when frame_valid = 1.
- Throughput: one byte per cycle sustained, with no bubble required between frames except the HOLD handshake.

Decomposition:
- Package uart_frame_pkg:
  - SOF_BYTE = 8'hA5, CRC8_POLY = 8'h07.
  - rx_state_t enum {HUNT, LEN, TYPE, PAYLOAD, CRC, HOLD}.
  - Function crc8_update(crc, byte), shared with the TX side.
- Sub-module: none required; the CRC is the package function applied once per accepted byte.

Test Plan:
- Good frame: bytes A5 02 01 03 04 64, one per 3 cycles -> frame_valid 1 cycle after the last byte; len = 02, type = 01, payload = {03, 04}; hold until frame_ready, then frame_valid = 0.
- Zero-length frame: A5 00 05 1B -> frame_valid with len = 0, type = 05; then A5 00 05 1C -> crc_err pulse, no frame_valid.
- Resync and embedded SOF:
  - Garbage 11 22 then A5 02 01 A5 04 (CRC recomputed by the model) -> garbage ignored, payload = {A5, 04} accepted.
  - Then A5 FF with MAX_PAYLOAD = 16 -> len_err pulse, return to HUNT.
- Backpressure: hold frame_ready = 0 after a good frame and send 3 bytes -> 3 drop pulses, outputs unchanged; assert frame_ready -> next frame parses normally.
- Timeout: TIMEOUT_CYCLES = 8, send A5 02 then idle 8 cycles -> timeout_err pulse, HUNT; a following good frame is accepted.
- Reset mid-frame: send A5 02 01 03, then rst for 1 cycle, then a full good frame -> no error pulses, only the second frame delivered.
